// File: rtl/comp_result_tracker.sv
// comp_result_tracker: consumes the gt/eq/lt flags of a 4-bit comparator.
// It tallies each valid comparison over a frame of FRAME_LEN samples and
// counts any sample whose flags are not one-hot as an error. The frame
// totals are offered downstream over a valid/ready handshake.
// Optional feature macro: COMP_TRACK_STREAK_EN adds the max_streak output,
// which reports the longest run of identical legal results in the frame.
module comp_result_tracker #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             gt,
  input  logic             eq,
  input  logic             lt,
  input  logic             out_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] err_cnt
`ifdef COMP_TRACK_STREAK_EN
  ,
  output logic [CNT_W-1:0] max_streak
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] sample_cnt;

  logic             is_gt;
  logic             is_eq;
  logic             is_lt;
  logic             legal;
  logic             frame_start;
  logic             take;
  logic             last_sample;

  assign is_gt = gt & ~eq & ~lt;
  assign is_eq = ~gt & eq & ~lt;
  assign is_lt = ~gt & ~eq & lt;
  assign legal = is_gt | is_eq | is_lt;

  // A new frame starts from IDLE, or from HOLD when the totals are accepted
  // in the same cycle; the latter gives back-to-back frames with no gap.
  assign frame_start = start & ((state_q == IDLE) |
                                ((state_q == HOLD) & out_ready));
  assign take        = (state_q == COUNT) & in_valid;
  assign last_sample = take & (sample_cnt == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = COUNT;
      end
      COUNT: begin
        if (last_sample) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = start ? COUNT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake/status outputs decoded straight from the state register.
  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      COUNT:   busy      = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Frame counters: cleared at frame start, advanced on each counted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      gt_cnt     <= '0;
      eq_cnt     <= '0;
      lt_cnt     <= '0;
      err_cnt    <= '0;
    end else if (frame_start) begin
      sample_cnt <= '0;
      gt_cnt     <= '0;
      eq_cnt     <= '0;
      lt_cnt     <= '0;
      err_cnt    <= '0;
    end else if (take) begin
      sample_cnt <= sample_cnt + ONE;
      if (is_gt) gt_cnt  <= gt_cnt + ONE;
      if (is_eq) eq_cnt  <= eq_cnt + ONE;
      if (is_lt) lt_cnt  <= lt_cnt + ONE;
      if (!legal) err_cnt <= err_cnt + ONE;
    end
  end

`ifdef COMP_TRACK_STREAK_EN
  logic [1:0]       res_code;
  logic [1:0]       last_code;
  logic [CNT_W-1:0] run_len;
  logic [CNT_W-1:0] run_len_d;

  assign res_code  = is_lt ? 2'd2 : (is_eq ? 2'd1 : 2'd0);
  // run_len == 0 means no run in progress, so last_code is stale then.
  assign run_len_d = ((run_len != '0) && (res_code == last_code)) ?
                     run_len + ONE : ONE;

  // Streak tracking: gaps in in_valid keep the run, error samples end it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_len    <= '0;
      last_code  <= '0;
      max_streak <= '0;
    end else if (frame_start) begin
      run_len    <= '0;
      last_code  <= '0;
      max_streak <= '0;
    end else if (take) begin
      if (legal) begin
        run_len   <= run_len_d;
        last_code <= res_code;
        if (run_len_d > max_streak) max_streak <= run_len_d;
      end else begin
        run_len <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_comp_result_tracker.sv
// Directed self-checking bench for comp_result_tracker (FRAME_LEN=4, CNT_W=3).
// With COMP_TRACK_STREAK_EN defined, a second instance (FRAME_LEN=6) checks
// the max_streak output.
module tb_comp_result_tracker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       gt;
  logic       eq;
  logic       lt;
  logic       out_ready;
  logic       busy;
  logic       out_valid;
  logic [2:0] gt_cnt;
  logic [2:0] eq_cnt;
  logic [2:0] lt_cnt;
  logic [2:0] err_cnt;

  int n_tests;
  int n_fail;

`ifdef COMP_TRACK_STREAK_EN
  logic [2:0] max_streak;
  logic       busy6;
  logic       out_valid6;
  logic [2:0] gt_cnt6;
  logic [2:0] eq_cnt6;
  logic [2:0] lt_cnt6;
  logic [2:0] err_cnt6;
  logic [2:0] max_streak6;
`endif

  comp_result_tracker #(
    .FRAME_LEN (4),
    .CNT_W     (3)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .gt        (gt),
    .eq        (eq),
    .lt        (lt),
    .out_ready (out_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .gt_cnt    (gt_cnt),
    .eq_cnt    (eq_cnt),
    .lt_cnt    (lt_cnt),
    .err_cnt   (err_cnt)
`ifdef COMP_TRACK_STREAK_EN
    ,
    .max_streak(max_streak)
`endif
  );

`ifdef COMP_TRACK_STREAK_EN
  comp_result_tracker #(
    .FRAME_LEN (6),
    .CNT_W     (3)
  ) u_dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .gt        (gt),
    .eq        (eq),
    .lt        (lt),
    .out_ready (out_ready),
    .busy      (busy6),
    .out_valid (out_valid6),
    .gt_cnt    (gt_cnt6),
    .eq_cnt    (eq_cnt6),
    .lt_cnt    (lt_cnt6),
    .err_cnt   (err_cnt6),
    .max_streak(max_streak6)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs changed 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one valid sample for exactly one clock edge.
  task automatic sample(input logic [2:0] f);
    in_valid     = 1'b1;
    {gt, eq, lt} = f;
    step();
    in_valid     = 1'b0;
    {gt, eq, lt} = 3'b000;
  endtask

  task automatic begin_frame();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    {gt, eq, lt} = 3'b000;
    out_ready = 1'b1;
    #2;
    apply_reset();

    // Reset state.
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_counts", {gt_cnt, eq_cnt, lt_cnt, err_cnt}, 0);

    // 1: gt, eq, lt, gt with out_ready=1.
    begin_frame();
    check("t1_busy", busy, 1);
    sample(3'b100);
    sample(3'b010);
    sample(3'b001);
    check("t1_no_early_valid", out_valid, 0);
    sample(3'b100);
    check("t1_out_valid", out_valid, 1);
    check("t1_busy_low", busy, 0);
    check("t1_gt", gt_cnt, 2);
    check("t1_eq", eq_cnt, 1);
    check("t1_lt", lt_cnt, 1);
    check("t1_err", err_cnt, 0);
    step();
    check("t1_idle_valid", out_valid, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_gt_kept", gt_cnt, 2);

    // 2: illegal patterns count as errors only.
    begin_frame();
    check("t2_cleared", {gt_cnt, eq_cnt, lt_cnt, err_cnt}, 0);
    sample(3'b100);
    sample(3'b000);
    sample(3'b110);
    sample(3'b001);
    check("t2_out_valid", out_valid, 1);
    check("t2_gt", gt_cnt, 1);
    check("t2_eq", eq_cnt, 0);
    check("t2_lt", lt_cnt, 1);
    check("t2_err", err_cnt, 2);
    step();

    // 3: gaps in in_valid are not counted.
    begin_frame();
    begin
      logic [6:0] pat;
      pat = 7'b1011001;   // cycle 1 is bit 6
      for (int i = 0; i < 7; i++) begin
        in_valid     = pat[6-i];
        {gt, eq, lt} = 3'b010;
        step();
        if (i < 6) begin
          check("t3_busy", busy, 1);
          check("t3_no_valid", out_valid, 0);
        end
      end
      in_valid     = 1'b0;
      {gt, eq, lt} = 3'b000;
    end
    check("t3_out_valid", out_valid, 1);
    check("t3_eq", eq_cnt, 4);
    step();

    // 4: backpressure holds the result, then back-to-back frame.
    out_ready = 1'b0;
    begin_frame();
    for (int i = 0; i < 4; i++) sample(3'b001);
    check("t4_out_valid", out_valid, 1);
    // Driving samples during HOLD must not disturb the totals.
    for (int i = 0; i < 5; i++) begin
      in_valid     = 1'b1;
      {gt, eq, lt} = 3'b100;
      step();
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_lt", lt_cnt, 4);
      check("t4_hold_gt", gt_cnt, 0);
    end
    in_valid     = 1'b0;
    {gt, eq, lt} = 3'b000;
    out_ready    = 1'b1;
    start        = 1'b1;
    step();
    start        = 1'b0;
    check("t4_b2b_busy", busy, 1);
    check("t4_b2b_valid", out_valid, 0);
    check("t4_b2b_cleared", {gt_cnt, eq_cnt, lt_cnt, err_cnt}, 0);

    // 5: asynchronous reset mid-frame.
    sample(3'b100);
    sample(3'b100);
    check("t5_pre_gt", gt_cnt, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_busy", busy, 0);
    check("t5_async_valid", out_valid, 0);
    check("t5_async_counts", {gt_cnt, eq_cnt, lt_cnt, err_cnt}, 0);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample(3'b100);
      check("t5_idle_valid", out_valid, 0);
      check("t5_idle_busy", busy, 0);
    end
    check("t5_idle_gt", gt_cnt, 0);
    begin_frame();
    for (int i = 0; i < 3; i++) sample(3'b010);
    check("t5_no_early_valid", out_valid, 0);
    sample(3'b010);
    check("t5_out_valid", out_valid, 1);
    check("t5_eq", eq_cnt, 4);
    step();

`ifdef COMP_TRACK_STREAK_EN
    // 6: longest legal run, broken by an error sample.
    apply_reset();
    begin_frame();
    sample(3'b001);
    sample(3'b001);
    sample(3'b001);
    sample(3'b000);
    sample(3'b100);
    sample(3'b100);
    check("t6_out_valid", out_valid6, 1);
    check("t6_max_streak", max_streak6, 3);
    check("t6_err", err_cnt6, 1);
    check("t6_lt", lt_cnt6, 3);
    check("t6_gt", gt_cnt6, 2);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
